// File: rtl/pcs_ber_pkg.sv
// Shared types and constants for the 64b/66b receive-side BER monitor.
// The header classifier lives here so the block-lock logic can reuse it.
package pcs_ber_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_TEST = 2'd1,
    ST_HI   = 2'd2
  } ber_state_e;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  localparam int DEF_TIMER_CYCLES = 19531;
  localparam int DEF_BER_THRESH   = 16;
  localparam int DEF_TIMER_W      = 15;
  localparam int BER_COUNT_W      = 6;

  // Only 01 and 10 are legal sync headers.
  function automatic logic is_bad_hdr(input logic [1:0] hdr);
    return (hdr != SH_DATA) && (hdr != SH_CTRL);
  endfunction

endpackage

// File: rtl/pcs_ber_timer.sv
// Loadable down-counter: counts CYCLES-1..0 while enabled and wraps on expiry.
// reload has priority over en; done is high while the count sits at zero.
module pcs_ber_timer #(
  parameter int CYCLES = 19531,
  parameter int W      = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic reload,
  output logic done
);

  localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

  logic [W-1:0] count;

  assign done = (count == '0);

  always_ff @(posedge clk) begin
    if (rst || reload) begin
      count <= LOAD;
    end else if (en) begin
      count <= done ? LOAD : count - W'(1);
    end
  end

endmodule

// File: rtl/pcs_ber_monitor.sv
// Receive-path BER monitor: counts invalid sync headers per window, drives
// hi_ber to the 66b decoder and keeps clear-on-read status for management.
module pcs_ber_monitor
  import pcs_ber_pkg::*;
#(
  parameter int TIMER_CYCLES = DEF_TIMER_CYCLES,
  parameter int BER_THRESH   = DEF_BER_THRESH,
  parameter int TIMER_W      = DEF_TIMER_W
) (
  input  logic                   clk156,
  input  logic                   rst156,
  input  logic                   blk_valid,
  input  logic [1:0]             sync_hdr,
  input  logic                   blk_lock,
  input  logic                   test_mode,
  input  logic                   clr_status,
  output logic                   hi_ber,
  output logic                   hi_ber_ll,
  output logic [BER_COUNT_W-1:0] ber_count,
  output logic                   win_done
);

  localparam logic [5:0] THRESH = 6'(BER_THRESH);

  function automatic logic [BER_COUNT_W-1:0] sat_inc(input logic [BER_COUNT_W-1:0] v);
    return (&v) ? v : v + BER_COUNT_W'(1);
  endfunction

  ber_state_e state, state_nxt;
  logic [4:0] win_cnt, win_cnt_nxt;
  logic [5:0] win_sum;
  logic       hi_ber_nxt;
  logic       bad, cnt_bad;
  logic       tmr_en, tmr_reload, tmr_done;

  assign bad     = blk_valid & is_bad_hdr(sync_hdr);
  assign win_sum = {1'b0, win_cnt} + 6'(bad);
  // The status counter runs in TEST/HI only, and stops the moment lock is lost.
  assign cnt_bad = bad & (state != ST_INIT) & blk_lock & ~test_mode;

  pcs_ber_timer #(
    .CYCLES (TIMER_CYCLES),
    .W      (TIMER_W)
  ) u_timer (
    .clk    (clk156),
    .rst    (rst156),
    .en     (tmr_en),
    .reload (tmr_reload),
    .done   (tmr_done)
  );

  always_comb begin
    state_nxt   = state;
    win_cnt_nxt = win_cnt;
    hi_ber_nxt  = hi_ber;
    tmr_en      = 1'b0;
    tmr_reload  = 1'b0;
    if (!blk_lock || test_mode) begin
      state_nxt   = ST_INIT;
      win_cnt_nxt = '0;
      hi_ber_nxt  = 1'b0;
      tmr_reload  = 1'b1;
    end else begin
      unique case (state)
        ST_TEST: begin
          tmr_en = 1'b1;
          // Threshold wins over a coincident window expiry.
          if (win_sum == THRESH) begin
            hi_ber_nxt  = 1'b1;
            state_nxt   = ST_HI;
            win_cnt_nxt = '0;
            tmr_reload  = 1'b1;
          end else if (tmr_done) begin
            hi_ber_nxt  = 1'b0;
            win_cnt_nxt = '0;
          end else begin
            win_cnt_nxt = win_sum[4:0];
          end
        end
        ST_HI: begin
          tmr_en = 1'b1;
          if (tmr_done) begin
            win_cnt_nxt = '0;
            state_nxt   = ST_TEST;
          end
        end
        default: begin
          state_nxt   = ST_TEST;
          win_cnt_nxt = '0;
          hi_ber_nxt  = 1'b0;
          tmr_reload  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk156) begin
    if (rst156) begin
      state     <= ST_INIT;
      win_cnt   <= '0;
      hi_ber    <= 1'b0;
      hi_ber_ll <= 1'b0;
      ber_count <= '0;
      win_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      win_cnt   <= win_cnt_nxt;
      hi_ber    <= hi_ber_nxt;
      win_done  <= tmr_en & tmr_done;
      // The latch cannot be cleared while hi_ber is still asserted.
      hi_ber_ll <= hi_ber | hi_ber_nxt | (hi_ber_ll & ~clr_status);
      if (clr_status) begin
        ber_count <= BER_COUNT_W'(cnt_bad);
      end else if (cnt_bad) begin
        ber_count <= sat_inc(ber_count);
      end
    end
  end

endmodule

// File: tb/tb_pcs_ber_monitor.sv
// Directed bench for pcs_ber_monitor with a 64-cycle window and threshold 16.
module tb_pcs_ber_monitor;

  logic       clk156 = 1'b0;
  logic       rst156 = 1'b0;
  logic       blk_valid = 1'b0;
  logic [1:0] sync_hdr = 2'b01;
  logic       blk_lock = 1'b0;
  logic       test_mode = 1'b0;
  logic       clr_status = 1'b0;
  logic       hi_ber;
  logic       hi_ber_ll;
  logic [5:0] ber_count;
  logic       win_done;

  int checks = 0;
  int errors = 0;

  pcs_ber_monitor #(
    .TIMER_CYCLES (64),
    .BER_THRESH   (16),
    .TIMER_W      (6)
  ) dut (
    .clk156     (clk156),
    .rst156     (rst156),
    .blk_valid  (blk_valid),
    .sync_hdr   (sync_hdr),
    .blk_lock   (blk_lock),
    .test_mode  (test_mode),
    .clr_status (clr_status),
    .hi_ber     (hi_ber),
    .hi_ber_ll  (hi_ber_ll),
    .ber_count  (ber_count),
    .win_done   (win_done)
  );

  always #5 clk156 = ~clk156;

  task automatic tick();
    @(posedge clk156);
    #1;
  endtask

  task automatic send(input logic [1:0] h);
    blk_valid = 1'b1;
    sync_hdr  = h;
    tick();
  endtask

  task automatic do_reset();
    rst156 = 1'b1; blk_lock = 1'b0; blk_valid = 1'b0; sync_hdr = 2'b01;
    test_mode = 1'b0; clr_status = 1'b0;
    tick();
    rst156 = 1'b0;
  endtask

  task automatic lock_up();
    blk_lock = 1'b1;
    blk_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (hi_ber !== 1'b0) begin errors++; $display("FAIL rst_hi_ber got %0b want 0", hi_ber); end
    checks++; if (hi_ber_ll !== 1'b0) begin errors++; $display("FAIL rst_hi_ber_ll got %0b want 0", hi_ber_ll); end
    checks++; if (ber_count !== 6'd0) begin errors++; $display("FAIL rst_ber_count got %0d want 0", ber_count); end
    checks++; if (win_done !== 1'b0) begin errors++; $display("FAIL rst_win_done got %0b want 0", win_done); end
  endtask

  task automatic test_clean_windows();
    logic exp;
    do_reset();
    lock_up();
    for (int i = 1; i <= 200; i++) begin
      send(2'b01);
      exp = (i % 64 == 0);
      checks++; if (win_done !== exp) begin errors++; $display("FAIL clean_win_done cyc %0d got %0b want %0b", i, win_done, exp); end
    end
    checks++; if (hi_ber !== 1'b0) begin errors++; $display("FAIL clean_hi_ber got %0b want 0", hi_ber); end
    checks++; if (ber_count !== 6'd0) begin errors++; $display("FAIL clean_ber_count got %0d want 0", ber_count); end
  endtask

  task automatic test_threshold();
    do_reset();
    lock_up();
    for (int i = 0; i < 15; i++) send(2'b00);
    checks++; if (hi_ber !== 1'b0) begin errors++; $display("FAIL thr_hi_ber_15 got %0b want 0", hi_ber); end
    send(2'b00);
    checks++; if (hi_ber !== 1'b1) begin errors++; $display("FAIL thr_hi_ber_16 got %0b want 1", hi_ber); end
    checks++; if (ber_count !== 6'd16) begin errors++; $display("FAIL thr_ber_count got %0d want 16", ber_count); end
    checks++; if (hi_ber_ll !== 1'b1) begin errors++; $display("FAIL thr_hi_ber_ll got %0b want 1", hi_ber_ll); end
    for (int i = 0; i < 127; i++) send(2'b01);
    checks++; if (hi_ber !== 1'b1) begin errors++; $display("FAIL thr_hold_127 got %0b want 1", hi_ber); end
    send(2'b01);
    checks++; if (hi_ber !== 1'b0) begin errors++; $display("FAIL thr_fall_128 got %0b want 0", hi_ber); end
    checks++; if (hi_ber_ll !== 1'b1) begin errors++; $display("FAIL thr_ll_kept got %0b want 1", hi_ber_ll); end
    blk_valid = 1'b0;
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    checks++; if (hi_ber_ll !== 1'b0) begin errors++; $display("FAIL thr_ll_clr got %0b want 0", hi_ber_ll); end
    checks++; if (ber_count !== 6'd0) begin errors++; $display("FAIL thr_cnt_clr got %0d want 0", ber_count); end
  endtask

  task automatic test_below_thresh();
    logic hi_seen;
    hi_seen = 1'b0;
    do_reset();
    lock_up();
    for (int w = 0; w < 4; w++) begin
      for (int c = 0; c < 64; c++) begin
        send((c < 15) ? 2'b00 : 2'b01);
        if (hi_ber !== 1'b0) hi_seen = 1'b1;
      end
    end
    checks++; if (hi_seen !== 1'b0) begin errors++; $display("FAIL below_hi_ber got %0b want 0", hi_seen); end
    checks++; if (ber_count !== 6'd60) begin errors++; $display("FAIL below_ber_count got %0d want 60", ber_count); end
    for (int i = 0; i < 3; i++) send(2'b00);
    checks++; if (ber_count !== 6'd63) begin errors++; $display("FAIL sat_63 got %0d want 63", ber_count); end
    send(2'b00);
    checks++; if (ber_count !== 6'd63) begin errors++; $display("FAIL sat_hold got %0d want 63", ber_count); end
  endtask

  task automatic test_thresh_on_expiry();
    do_reset();
    lock_up();
    for (int i = 0; i < 48; i++) send(2'b01);
    for (int i = 0; i < 15; i++) send(2'b00);
    checks++; if (hi_ber !== 1'b0) begin errors++; $display("FAIL exp_hi_ber_pre got %0b want 0", hi_ber); end
    send(2'b00);
    checks++; if (hi_ber !== 1'b1) begin errors++; $display("FAIL exp_hi_ber got %0b want 1", hi_ber); end
    checks++; if (win_done !== 1'b1) begin errors++; $display("FAIL exp_win_done got %0b want 1", win_done); end
    for (int i = 1; i <= 64; i++) begin
      send((i <= 10) ? 2'b00 : 2'b01);
      if (i == 63) begin
        checks++; if (win_done !== 1'b0) begin errors++; $display("FAIL hi_win_done_63 got %0b want 0", win_done); end
      end
    end
    checks++; if (win_done !== 1'b1) begin errors++; $display("FAIL hi_win_done_64 got %0b want 1", win_done); end
    checks++; if (hi_ber !== 1'b1) begin errors++; $display("FAIL hi_hold got %0b want 1", hi_ber); end
    for (int i = 1; i <= 64; i++) begin
      send((i <= 10) ? 2'b00 : 2'b01);
      if (i == 63) begin
        checks++; if (hi_ber !== 1'b1) begin errors++; $display("FAIL test2_hold_63 got %0b want 1", hi_ber); end
      end
    end
    checks++; if (hi_ber !== 1'b0) begin errors++; $display("FAIL test2_fall got %0b want 0", hi_ber); end
  endtask

  task automatic test_lock_drop();
    logic hi_seen;
    hi_seen = 1'b0;
    do_reset();
    lock_up();
    for (int i = 0; i < 16; i++) send(2'b00);
    checks++; if (hi_ber !== 1'b1) begin errors++; $display("FAIL lock_hi_ber got %0b want 1", hi_ber); end
    blk_lock = 1'b0;
    send(2'b00);
    checks++; if (hi_ber !== 1'b0) begin errors++; $display("FAIL lock_drop_hi_ber got %0b want 0", hi_ber); end
    blk_lock = 1'b1;
    send(2'b00);
    for (int i = 0; i < 6; i++) send(2'b00);
    blk_lock = 1'b0;
    send(2'b00);
    blk_lock = 1'b1;
    send(2'b00);
    for (int i = 1; i <= 64; i++) begin
      send((i <= 12) ? 2'b00 : 2'b01);
      if (hi_ber !== 1'b0) hi_seen = 1'b1;
      if (i == 63) begin
        checks++; if (win_done !== 1'b0) begin errors++; $display("FAIL relock_win_63 got %0b want 0", win_done); end
      end
    end
    checks++; if (win_done !== 1'b1) begin errors++; $display("FAIL relock_win_64 got %0b want 1", win_done); end
    checks++; if (hi_seen !== 1'b0) begin errors++; $display("FAIL relock_hi_ber got %0b want 0", hi_seen); end
    checks++; if (ber_count !== 6'd34) begin errors++; $display("FAIL relock_ber_count got %0d want 34", ber_count); end
  endtask

  task automatic test_clr_and_reset();
    do_reset();
    lock_up();
    for (int i = 0; i < 16; i++) send(2'b00);
    checks++; if (ber_count !== 6'd16) begin errors++; $display("FAIL clr_pre_count got %0d want 16", ber_count); end
    clr_status = 1'b1;
    send(2'b00);
    clr_status = 1'b0;
    checks++; if (ber_count !== 6'd1) begin errors++; $display("FAIL clr_bad_count got %0d want 1", ber_count); end
    checks++; if (hi_ber_ll !== 1'b1) begin errors++; $display("FAIL clr_ll_hold got %0b want 1", hi_ber_ll); end
    checks++; if (hi_ber !== 1'b1) begin errors++; $display("FAIL clr_hi_ber got %0b want 1", hi_ber); end
    for (int i = 0; i < 10; i++) send(2'b01);
    rst156 = 1'b1;
    tick();
    rst156 = 1'b0;
    checks++; if (hi_ber !== 1'b0) begin errors++; $display("FAIL mid_rst_hi_ber got %0b want 0", hi_ber); end
    checks++; if (hi_ber_ll !== 1'b0) begin errors++; $display("FAIL mid_rst_ll got %0b want 0", hi_ber_ll); end
    checks++; if (ber_count !== 6'd0) begin errors++; $display("FAIL mid_rst_count got %0d want 0", ber_count); end
    checks++; if (win_done !== 1'b0) begin errors++; $display("FAIL mid_rst_win_done got %0b want 0", win_done); end
  endtask

  initial begin
    test_reset();
    test_clean_windows();
    test_threshold();
    test_below_thresh();
    test_thresh_on_expiry();
    test_lock_drop();
    test_clr_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcs_ber_monitor.md
Name: pcs_ber_monitor

Overview:
- Clause-49-style bit-error-rate monitor for the 64b/66b receive path.
- Sits between block lock / descrambler and the 66b decoder, and drives that decoder's hi_ber input.
- Counts invalid sync headers (00 or 11) inside fixed 125 us windows. Asserts hi_ber when a window's count reaches threshold, and deasserts it after a clean window.
- Keeps a 6-bit saturating clear-on-read ber_count and a latched-high hi_ber status for management.

Parameters:
- TIMER_CYCLES, 19531, window length in clk156 cycles (125 us at 156.25 MHz); must be >= 2.
- BER_THRESH, 16, invalid headers per window that trigger hi_ber; range 1..31.
- TIMER_W, 15, timer width; must satisfy 2**TIMER_W >= TIMER_CYCLES.

Ports:
- clk156  in  1  receive clock, 156.25 MHz.
- rst156  in  1  reset, synchronous, active-high.
- blk_valid  in  1  one new 66b block header presented this cycle.
- sync_hdr  in  2  sync header of that block (DeScr_RXD[1:0]); 01/10 valid, 00/11 invalid.
- blk_lock  in  1  block lock from the lock FSM.
- test_mode  in  1  PRBS/test-pattern mode; suspends monitoring.
- clr_status  in  1  one-cycle clear-on-read pulse for ber_count and hi_ber_ll.
- hi_ber  out  1  high-BER indication to the decoder.
- hi_ber_ll  out  1  latched-high copy of hi_ber.
- ber_count  out  6  saturating count of invalid headers since last clr_status.
- win_done  out  1  one-cycle pulse at each window expiry.

Behaviour:
- Reset: all outputs 0, state INIT, timer = TIMER_CYCLES-1, win_cnt = 0. Everything is registered; no combinational input-to-output paths.
- bad = blk_valid & (sync_hdr==2'b00 | sync_hdr==2'b11).
- Timer: decrements each cycle in TEST/HI. timer_done = (timer==0). On timer_done it reloads TIMER_CYCLES-1, and win_done pulses 1 cycle later.
- States:
  - INIT: entered on reset, or from any state whenever blk_lock==0 or test_mode==1. Effects: hi_ber<=0, win_cnt<=0, timer<=TIMER_CYCLES-1. Leaves for TEST on the first cycle with blk_lock=1 & test_mode=0. In that exit cycle: no counting, timer not decremented.
  - TEST: on bad, win_cnt<=win_cnt+1.
    - If win_cnt+bad==BER_THRESH: hi_ber<=1, go HI, win_cnt<=0, timer reloads.
    - Else if timer_done: hi_ber<=0, win_cnt<=0.
    - Threshold takes priority over a simultaneous timer_done.
  - HI: bad headers are not accumulated into the window. On timer_done: win_cnt<=0, go TEST, hi_ber stays 1. hi_ber falls only on a TEST-window expiry with win_cnt+bad < BER_THRESH. So minimum hi_ber pulse = two windows.
- hi_ber latency: registered; visible the cycle after the threshold-reaching header is sampled.
- ber_count (all states except INIT; counting stops while unlocked):
  - Increments on bad and saturates at 63.
  - clr_status together with bad gives ber_count=1.
  - clr_status alone gives 0.
- hi_ber_ll:
  - Set whenever hi_ber==1.
  - clr_status clears it only if hi_ber==0 that cycle; otherwise it stays 1.
- Reset mid-window: full reinit, no partial-window carryover.
- blk_lock drop: hi_ber deasserts the next cycle, which matches the decoder's expectation that lock loss drives its own LF path.

Decomposition:
- Shared package pcs_ber_pkg:
  - state enum {INIT, TEST, HI} (2 bits);
  - SH_DATA=2'b01, SH_CTRL=2'b10;
  - default window / threshold constants.
- One sub-module, pcs_ber_timer: loadable down-counter with enable, reload and done. Reused by the future block-lock timer.
- The FSM, window counter and status counters stay in pcs_ber_monitor.

Test Plan (TIMER_CYCLES=64, BER_THRESH=16 unless noted):
1. Lock, 200 cycles of blk_valid with sync_hdr=01 -> hi_ber=0, ber_count=0, win_done pulses every 64 cycles.
2. 16 headers of 00 inside one window -> hi_ber=1 the cycle after the 16th. ber_count=16, hi_ber_ll=1. After two clean windows hi_ber=0 and hi_ber_ll stays 1 until clr_status.
3. 15 bad headers per window for 4 windows -> hi_ber never asserts; ber_count=60. Add 4 more -> ber_count saturates at 63.
4. 16th bad header on the exact timer_done cycle -> hi_ber=1 (threshold priority); state HI for a full 64-cycle window.
5. While hi_ber=1, drop blk_lock for 1 cycle -> hi_ber=0 next cycle, win_cnt cleared; relock restarts a fresh 64-cycle window.
6. clr_status coincident with bad while hi_ber=1 -> ber_count=1, hi_ber_ll stays 1. Apply rst156 mid-window -> all outputs 0 next cycle.
